// File: rtl/fetch_sequencer.sv
// PC sequencer with redirect bubble and return-address storage.
// Define FETCH_RAS_EN for a RAS_DEPTH stack; otherwise a single link register.
module fetch_sequencer #(
    parameter int unsigned      WIDTH     = 6,
    parameter int unsigned      RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] IncPC,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             Cond,
    input  logic             Jump,
    input  logic             Call,
    input  logic             Ret,
    input  logic [WIDTH-1:0] Target,
    output logic [WIDTH-1:0] PC,
    output logic             Valid,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasErr
);

    typedef enum logic {
        RUN,
        BUBBLE
    } state_e;

    if (RAS_DEPTH < 2 || RAS_DEPTH > 8 ||
        (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RAS_DEPTH must be a power of two in 2..8");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             err_q, err_d;
    logic             push, pop;
    logic [WIDTH-1:0] top;
    logic             empty, full;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (!Stall) begin
            if (state_q == BUBBLE) begin
                pc_d    = IncPC;
                state_d = RUN;
            end else if (Ret && !empty) begin
                pc_d    = top;
                pop     = 1'b1;
                state_d = BUBBLE;
            end else if (Ret) begin
                // Underflow falls through as a plain sequential fetch.
                pc_d  = IncPC;
                err_d = 1'b1;
            end else if (Call) begin
                pc_d    = Target;
                push    = 1'b1;
                state_d = BUBBLE;
                if (full) begin
                    err_d = 1'b1;
                end
            end else if (Jump || (Branch && Cond)) begin
                pc_d    = Target;
                state_d = BUBBLE;
            end else begin
                pc_d = IncPC;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= BUBBLE;
            pc_q    <= RESET_PC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

`ifdef FETCH_RAS_EN
    localparam int unsigned PTRW = $clog2(RAS_DEPTH);
    localparam int unsigned CNTW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [PTRW-1:0]  ptr_q, ptr_d;
    logic [PTRW-1:0]  ptr_dec;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    // ptr_q is the next free slot; the newest entry sits just below it.
    assign ptr_dec = ptr_q - PTRW'(1);
    assign top     = ras_q[ptr_dec];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNTW'(RAS_DEPTH));

    always_comb begin
        ras_d = ras_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ras_d[ptr_q] = IncPC;
            ptr_d        = ptr_q + PTRW'(1);
            if (!full) begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end else if (pop) begin
            ptr_d = ptr_dec;
            cnt_d = cnt_q - CNTW'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ras_q <= ras_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end
`else
    logic [WIDTH-1:0] link_q, link_d;
    logic             full_q, full_d;

    assign top   = link_q;
    assign full  = full_q;
    assign empty = ~full_q;

    always_comb begin
        link_d = link_q;
        full_d = full_q;
        if (push) begin
            link_d = IncPC;
            full_d = 1'b1;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            link_q <= '0;
            full_q <= 1'b0;
        end else begin
            link_q <= link_d;
            full_q <= full_d;
        end
    end
`endif

    assign PC       = pc_q;
    assign Valid    = (state_q == RUN);
    assign RasEmpty = empty;
    assign RasFull  = full;
    assign RasErr   = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed plan plus random requests
// against a queue-based reference model of the return-address storage.
module tb_fetch_sequencer;

`ifdef FETCH_RAS_EN
    localparam int M_DEPTH = 4;
`else
    localparam int M_DEPTH = 1;
`endif

    logic       clk;
    logic       rst;
    logic [5:0] inc_pc;
    logic       stall, branch, cond, jump, call, ret;
    logic [5:0] target;
    logic [5:0] pc;
    logic       valid, ras_empty, ras_full, ras_err;

    fetch_sequencer #(
        .WIDTH    (6),
        .RAS_DEPTH(4),
        .RESET_PC (6'd0)
    ) dut (
        .Clk     (clk),
        .Reset   (rst),
        .IncPC   (inc_pc),
        .Stall   (stall),
        .Branch  (branch),
        .Cond    (cond),
        .Jump    (jump),
        .Call    (call),
        .Ret     (ret),
        .Target  (target),
        .PC      (pc),
        .Valid   (valid),
        .RasEmpty(ras_empty),
        .RasFull (ras_full),
        .RasErr  (ras_err)
    );

    // External PC+1 adder fed from the block's own PC.
    assign inc_pc = pc + 6'd1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [5:0] pc;
        logic       valid;
        logic       empty;
        logic       full;
        logic       err;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    logic [5:0] m_pc;
    bit         m_bubble;
    bit         m_err;
    logic [5:0] m_stack[$];

    function automatic void model_reset();
        m_pc     = 6'd0;
        m_bubble = 1'b1;
        m_err    = 1'b0;
        m_stack.delete();
    endfunction

    function automatic void model_step(bit r, bit c, bit j, bit b, bit cd,
                                       logic [5:0] t, bit s);
        logic [5:0] inc;
        inc = m_pc + 6'd1;
        if (s) return;
        if (m_bubble) begin
            m_pc     = inc;
            m_bubble = 1'b0;
        end else if (r && m_stack.size() > 0) begin
            m_pc     = m_stack.pop_back();
            m_bubble = 1'b1;
        end else if (r) begin
            m_pc  = inc;
            m_err = 1'b1;
        end else if (c) begin
            if (m_stack.size() == M_DEPTH) begin
                void'(m_stack.pop_front());
                m_err = 1'b1;
            end
            m_stack.push_back(inc);
            m_pc     = t;
            m_bubble = 1'b1;
        end else if (j || (b && cd)) begin
            m_pc     = t;
            m_bubble = 1'b1;
        end else begin
            m_pc = inc;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.pc    = m_pc;
        e.valid = !m_bubble;
        e.empty = (m_stack.size() == 0);
        e.full  = (m_stack.size() == M_DEPTH);
        e.err   = m_err;
        return e;
    endfunction

    task automatic step(input bit r, input bit c, input bit j, input bit b,
                        input bit cd, input logic [5:0] t, input bit s);
        @(negedge clk);
        ret    = r;
        call   = c;
        jump   = j;
        branch = b;
        cond   = cd;
        target = t;
        stall  = s;
        @(posedge clk);
        model_step(r, c, j, b, cd, t, s);
        sbq.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 6'd0, 0);
    endtask

    // Reset is pulsed between edges and checked before any edge arrives.
    task automatic do_reset();
        @(negedge clk);
        {ret, call, jump, branch, cond, stall} = '0;
        target = 6'd0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pc, valid, ras_empty, ras_full, ras_err} !== {6'd0, 4'b0100}) begin
            errors++;
            $display("FAIL async_reset: got pc=%0d v=%b e=%b f=%b err=%b, exp pc=0 v=0 e=1 f=0 err=0",
                     pc, valid, ras_empty, ras_full, ras_err);
        end
        model_reset();
        #1 rst = 1'b0;
        @(posedge clk);
        model_step(0, 0, 0, 0, 0, 6'd0, 0);
        sbq.push_back(model_out());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if ({pc, valid, ras_empty, ras_full, ras_err} !== e) begin
                    errors++;
                    $display("FAIL scoreboard @%0t: got pc=%0d v=%b e=%b f=%b err=%b, exp pc=%0d v=%b e=%b f=%b err=%b",
                             $time, pc, valid, ras_empty, ras_full, ras_err,
                             e.pc, e.valid, e.empty, e.full, e.err);
                end
            end
        end
    end

    initial begin : driver
        int guard;
        rst    = 1'b1;
        {ret, call, jump, branch, cond, stall} = '0;
        target = 6'd0;
        model_reset();
        do_reset();
        idle(5);

        // Jump at PC=10, then a not-taken branch.
        while (m_pc != 6'd10) idle(1);
        step(0, 0, 1, 0, 0, 6'd40, 0);
        idle(2);
        step(0, 0, 1, 0, 0, 6'd9, 0);
        idle(1);
        step(0, 0, 0, 1, 0, 6'd50, 0);
        idle(1);

        // Nested calls and returns.
        step(0, 0, 1, 0, 0, 6'd4, 0);
        idle(1);
        step(0, 1, 0, 0, 0, 6'd20, 0);
        idle(1);
        step(0, 1, 0, 0, 0, 6'd30, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 6'd0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 6'd0, 0);
        idle(1);

        // Overflow with five calls, then drain with five returns.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0, 0, 6'(8 * i + 3), 0);
            idle(1);
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0, 6'd0, 0);
            idle(1);
        end

        // Priority, then the same combination under stall.
        do_reset();
        step(0, 1, 0, 0, 0, 6'd12, 0);
        idle(2);
        step(1, 0, 1, 1, 1, 6'd33, 0);
        idle(1);
        step(0, 1, 0, 0, 0, 6'd14, 0);
        idle(1);
        step(1, 1, 1, 1, 1, 6'd44, 1);
        step(1, 1, 1, 1, 1, 6'd44, 1);
        idle(2);

        // Sequential wrap from 63.
        step(0, 0, 1, 0, 0, 6'd62, 0);
        idle(3);

        // Reset during a bubble with stacked returns.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 6'(i + 1), 0);
            idle(1);
        end
        step(0, 0, 1, 0, 0, 6'd25, 0);
        do_reset();
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                     1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                     $urandom_range(0, 7) == 0);
            end
        end

        guard = 0;
        while (sbq.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, exp 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
